// File: rtl/async_fifo_pkg.sv
// Shared defaults and types for the FIFO write-side arbiter.
// Imported by the picker and by the arbiter top.
package async_fifo_pkg;

    localparam int unsigned DEF_WIDTH     = 8;
    localparam int unsigned DEF_N_REQ     = 4;
    localparam int unsigned DEF_MAX_BURST = 4;
    localparam int unsigned ERR_CNT_W     = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N_REQ.
module rr_arb_pick
    import async_fifo_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int unsigned cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        cand   = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = (32'(ptr) + k) % N_REQ;
            if (!any && req[cand]) begin
                any          = 1'b1;
                onehot[cand] = 1'b1;
                idx          = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst scheduler sharing one FIFO write port among N_REQ
// requesters; also counts FIFO write-error cycles (saturating).
module fifo_wr_arbiter
    import async_fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned N_REQ     = DEF_N_REQ,
    parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [N_REQ-1:0]       req_valid_i,
    input  logic [N_REQ*WIDTH-1:0] req_data_i,
    output logic [N_REQ-1:0]       req_ready_o,
    input  logic                   fifo_full_i,
    input  logic                   fifo_wr_error_i,
    output logic                   fifo_wr_en_o,
    output logic [WIDTH-1:0]       fifo_wdata_o,
    output logic [N_REQ-1:0]       grant_o,
    output logic                   busy_o,
    output logic [ERR_CNT_W-1:0]   err_cnt_o
);

    localparam int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned BEAT_W = $clog2(MAX_BURST) + 1;

    arb_state_e          state, state_nxt;
    logic [N_REQ-1:0]    grant, grant_nxt;
    logic [IDX_W-1:0]    gidx, gidx_nxt;
    logic [IDX_W-1:0]    rr_ptr, rr_ptr_nxt;
    logic [BEAT_W-1:0]   beat_cnt, beat_nxt;
    logic [ERR_CNT_W-1:0] err_cnt;

    logic                in_burst;
    logic [N_REQ-1:0]    ready;
    logic                transfer;
    logic                cur_valid;
    logic                last_beat;
    logic                release_burst;
    logic [IDX_W-1:0]    ptr_after;
    logic [IDX_W-1:0]    pick_ptr;
    logic [N_REQ-1:0]    pick_onehot;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;

    always_comb begin
        in_burst  = (state == BURST);
        ready     = grant & {N_REQ{in_burst}} & {N_REQ{~fifo_full_i}};
        transfer  = |(req_valid_i & ready);
        cur_valid = req_valid_i[gidx];
        last_beat = (beat_cnt == BEAT_W'(MAX_BURST - 1));
        // Full stalls the burst: it neither counts a beat nor releases on a dropped valid.
        release_burst = in_burst &&
                        ((transfer && last_beat) || (!cur_valid && !fifo_full_i));
        ptr_after = (gidx == IDX_W'(N_REQ - 1)) ? '0 : gidx + IDX_W'(1);
        // On release the next winner is chosen from the advanced pointer in the same cycle.
        pick_ptr  = in_burst ? ptr_after : rr_ptr;
    end

    rr_arb_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req    (req_valid_i),
        .ptr    (pick_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant;
        gidx_nxt   = gidx;
        rr_ptr_nxt = rr_ptr;
        beat_nxt   = beat_cnt;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nxt = BURST;
                    grant_nxt = pick_onehot;
                    gidx_nxt  = pick_idx;
                    beat_nxt  = '0;
                end
            end
            BURST: begin
                if (release_burst) begin
                    rr_ptr_nxt = ptr_after;
                    beat_nxt   = '0;
                    if (pick_any) begin
                        state_nxt = BURST;
                        grant_nxt = pick_onehot;
                        gidx_nxt  = pick_idx;
                    end else begin
                        state_nxt = IDLE;
                        grant_nxt = '0;
                    end
                end else if (transfer) begin
                    beat_nxt = beat_cnt + BEAT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
                beat_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            grant    <= '0;
            gidx     <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            gidx     <= gidx_nxt;
            rr_ptr   <= rr_ptr_nxt;
            beat_cnt <= beat_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_cnt <= '0;
        end else if (fifo_wr_error_i && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end

    assign req_ready_o  = ready;
    assign fifo_wr_en_o = transfer;
    assign fifo_wdata_o = in_burst ? req_data_i[gidx*WIDTH +: WIDTH] : '0;
    assign grant_o      = grant;
    assign busy_o       = in_burst;
    assign err_cnt_o    = err_cnt;

endmodule
